// File: rtl/canvas_pkg.sv
// Shared definitions for the canvas snapshot streamer: default geometry,
// coordinate and counter widths, and the streamer state encoding.
package canvas_pkg;
    localparam int CANVAS_W_DEF = 30;
    localparam int CANVAS_H_DEF = 30;
    localparam int COORD_W      = 5;
    localparam int INK_W        = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_t;
endpackage

// File: rtl/canvas_stats.sv
// Ink statistics for one streamed frame: ink pixel count and bounding box of
// every accepted ink pixel. All registers read zero until the first ink pixel.
module canvas_stats
    import canvas_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               xfer,
    input  logic               pixel,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    output logic [INK_W-1:0]   ink_count,
    output logic [COORD_W-1:0] rmin,
    output logic [COORD_W-1:0] rmax,
    output logic [COORD_W-1:0] cmin,
    output logic [COORD_W-1:0] cmax,
    output logic               bbox_valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ink_count <= '0;
            rmin      <= '0;
            rmax      <= '0;
            cmin      <= '0;
            cmax      <= '0;
        end else if (clear) begin
            ink_count <= '0;
            rmin      <= '0;
            rmax      <= '0;
            cmin      <= '0;
            cmax      <= '0;
        end else if (xfer && pixel) begin
            ink_count <= ink_count + 1'b1;
            // The first ink pixel seeds the box; zeros are not valid bounds.
            if (ink_count == '0) begin
                rmin <= row;
                rmax <= row;
                cmin <= col;
                cmax <= col;
            end else begin
                if (row < rmin) rmin <= row;
                if (row > rmax) rmax <= row;
                if (col < cmin) cmin <= col;
                if (col > cmax) cmax <= col;
            end
        end
    end

    assign bbox_valid = (ink_count != '0);
endmodule

// File: rtl/canvas_streamer.sv
// Snapshots the handwriting canvas on request and streams it pixel by pixel,
// row-major, over a valid/ready handshake while accumulating ink statistics.
module canvas_streamer
    import canvas_pkg::*;
#(
    parameter int CANVAS_W = CANVAS_W_DEF,
    parameter int CANVAS_H = CANVAS_H_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [CANVAS_W*CANVAS_H-1:0] i_handwrite,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic                         o_pixel,
    output logic [COORD_W-1:0]           o_row,
    output logic [COORD_W-1:0]           o_col,
    output logic                         o_last,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [INK_W-1:0]             o_ink_count,
    output logic [COORD_W-1:0]           o_bbox_rmin,
    output logic [COORD_W-1:0]           o_bbox_rmax,
    output logic [COORD_W-1:0]           o_bbox_cmin,
    output logic [COORD_W-1:0]           o_bbox_cmax,
    output logic                         o_bbox_valid
);
    localparam int NPIX = CANVAS_W * CANVAS_H;

    state_t            state;
    logic [NPIX-1:0]   snap;
    logic              xfer;
    logic              clear;

    assign xfer    = o_valid & i_ready;
    assign clear   = (state == IDLE) & i_start;
    // The snapshot shifts right on every transfer, so bit 0 is always the current pixel.
    assign o_pixel = snap[0];
    assign o_last  = o_valid && (o_row == COORD_W'(CANVAS_H - 1)) && (o_col == COORD_W'(CANVAS_W - 1));
    assign o_busy  = (state == LOAD) || (state == STREAM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            // NOTE: the snapshot is reset too so o_pixel reads 0 during and after reset.
            snap    <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            o_row   <= '0;
            o_col   <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        snap  <= i_handwrite;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state   <= STREAM;
                    o_valid <= 1'b1;
                    o_row   <= '0;
                    o_col   <= '0;
                end
                STREAM: begin
                    if (xfer) begin
                        snap <= snap >> 1;
                        if (o_last) begin
                            state   <= DONE;
                            o_valid <= 1'b0;
                            o_done  <= 1'b1;
                            o_row   <= '0;
                            o_col   <= '0;
                        end else if (o_col == COORD_W'(CANVAS_W - 1)) begin
                            o_col <= '0;
                            o_row <= o_row + 1'b1;
                        end else begin
                            o_col <= o_col + 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    canvas_stats u_stats (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (clear),
        .xfer      (xfer),
        .pixel     (o_pixel),
        .row       (o_row),
        .col       (o_col),
        .ink_count (o_ink_count),
        .rmin      (o_bbox_rmin),
        .rmax      (o_bbox_rmax),
        .cmin      (o_bbox_cmin),
        .cmax      (o_bbox_cmax),
        .bbox_valid(o_bbox_valid)
    );
endmodule

// File: tb/tb_canvas_streamer.sv
// Bench for canvas_streamer: streams directed and random frames under several
// ready patterns and compares every beat and the final statistics to a frame model.
module tb_canvas_streamer;
    localparam int W = 30;
    localparam int H = 30;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         ready;
    logic [N-1:0] handwrite;
    logic         valid, pixel, last, busy, done, bbox_valid;
    logic [4:0]   row, col, rmin, rmax, cmin, cmax;
    logic [9:0]   ink;

    logic [N-1:0] snap;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #20 clk = ~clk;

    canvas_streamer #(.CANVAS_W(W), .CANVAS_H(H)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_handwrite (handwrite),
        .i_ready     (ready),
        .o_valid     (valid),
        .o_pixel     (pixel),
        .o_row       (row),
        .o_col       (col),
        .o_last      (last),
        .o_busy      (busy),
        .o_done      (done),
        .o_ink_count (ink),
        .o_bbox_rmin (rmin),
        .o_bbox_rmax (rmax),
        .o_bbox_cmin (cmin),
        .o_bbox_cmax (cmax),
        .o_bbox_valid(bbox_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rand_frame();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) == 0);
        return r;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ctl"},  32'({valid, busy, done, last, pixel, bbox_valid}), 0);
        check({tag, "_pos"},  32'({row, col, rmin, rmax}), 0);
        check({tag, "_stat"}, 32'({cmin, cmax, ink}), 0);
    endtask

    // Expected statistics straight from the snapshot: count and extremes of ink positions.
    task automatic check_stats(input string tag);
        int cnt = 0;
        int r0 = H, r1 = -1, c0 = W, c1 = -1;
        for (int i = 0; i < N; i++) begin
            if (snap[i]) begin
                cnt++;
                if (i / W < r0) r0 = i / W;
                if (i / W > r1) r1 = i / W;
                if (i % W < c0) c0 = i % W;
                if (i % W > c1) c1 = i % W;
            end
        end
        if (cnt == 0) begin
            r0 = 0; r1 = 0; c0 = 0; c1 = 0;
        end
        check({tag, "_ink"},   32'(ink), cnt);
        check({tag, "_bbv"},   32'(bbox_valid), (cnt != 0) ? 1 : 0);
        check({tag, "_rmin"},  32'(rmin), r0);
        check({tag, "_rmax"},  32'(rmax), r1);
        check({tag, "_cmin"},  32'(cmin), c0);
        check({tag, "_cmax"},  32'(cmax), c1);
    endtask

    // Called at a falling edge: requests a frame, then checks LOAD and the first STREAM cycle.
    task automatic start_frame(input logic [N-1:0] bits, input logic [N-1:0] after);
        start     = 1'b1;
        handwrite = bits;
        snap      = bits;
        @(negedge clk);
        check("load_busy",  32'(busy), 1);
        check("load_valid", 32'(valid), 0);
        start     = 1'b0;
        handwrite = after;
        @(negedge clk);
        check("first_valid", 32'(valid), 1);
    endtask

    // mode 0: ready always high, 1: ready toggles starting low, 2: random ready.
    task automatic stream(input int mode, input int pulse_at, input int abort_at,
                          input bit hold_start, input logic [N-1:0] next_bits,
                          output int cycles);
        int k = 0;
        cycles = 0;
        while (k < N && cycles < 4 * N) begin
            if (k == abort_at) begin
                start = 1'b0;
                ready = 1'b0;
                #5 rst_n = 1'b0;
                #1 check_zero("abort_async");
                @(negedge clk);
                check_zero("abort_hold");
                rst_n = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'({done, busy, valid}), 0);
                end
                return;
            end
            check("valid", 32'(valid), 1);
            check("beat", 32'({pixel, row, col, last}),
                  32'({snap[k], 5'(k / W), 5'(k % W), k == N - 1}));
            start = (k == pulse_at);
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cycles % 2 == 1);
                default: ready = ($urandom_range(0, 2) != 0);
            endcase
            if (ready) k++;
            cycles++;
            @(negedge clk);
        end
        if (k < N) check("stream_timeout", k, N);
        ready     = 1'b0;
        start     = hold_start;
        handwrite = next_bits;
        check("done_pulse", 32'({done, valid, busy}), 32'(3'b100));
        check_stats("done");
        @(negedge clk);
        check("after_done", 32'({done, valid, busy}), 0);
        check_stats("hold");
    endtask

    initial begin
        int           cyc;
        logic [N-1:0] b, b2;
        rst_n     = 1'b0;
        start     = 1'b0;
        ready     = 1'b0;
        handwrite = '0;
        #30 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Empty canvas, ready always high.
        @(negedge clk);
        start_frame('0, '0);
        stream(0, -1, -1, 1'b0, '0, cyc);
        check("empty_cycles", cyc, N);

        // Single ink pixel in the middle, canvas scrambled after the snapshot.
        b = '0;
        b[465] = 1'b1;
        @(negedge clk);
        start_frame(b, rand_frame());
        stream(0, -1, -1, 1'b0, rand_frame(), cyc);

        // Ready toggling: every other cycle transfers.
        @(negedge clk);
        start_frame(rand_frame(), rand_frame());
        stream(1, -1, -1, 1'b0, '0, cyc);
        check("toggle_cycles", cyc, 2 * N);

        // Corner pixels only, canvas cleared after the snapshot.
        b = '0;
        b[0] = 1'b1;
        b[N-1] = 1'b1;
        @(negedge clk);
        start_frame(b, '0);
        stream(0, -1, -1, 1'b0, '0, cyc);

        // Random ready, stray start mid-stream, start held through DONE into IDLE.
        b2 = rand_frame();
        @(negedge clk);
        start_frame(rand_frame(), rand_frame());
        stream(2, 100, -1, 1'b1, b2, cyc);
        start_frame(b2, rand_frame());
        stream(2, -1, -1, 1'b0, '0, cyc);

        // Reset in the middle of a stream, then a clean stream from index 0.
        @(negedge clk);
        start_frame(rand_frame(), rand_frame());
        stream(2, -1, 500, 1'b0, '0, cyc);
        @(negedge clk);
        start_frame(rand_frame(), rand_frame());
        stream(0, -1, -1, 1'b0, '0, cyc);
        check("post_reset_cycles", cyc, N);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/canvas_streamer.md
CANVAS_STREAMER -- requirements
Module: canvas_streamer

Interface
REQ-001 SHALL have parameter CANVAS_W, default 30, canvas width in pixels.
REQ-002 SHALL have parameter CANVAS_H, default 30, canvas height in pixels.
REQ-003 SHALL have port i_clk  input  1  the only clock, 25 MHz VGA-domain clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  request to snapshot and stream the canvas.
REQ-006 SHALL have port i_handwrite  input  CANVAS_W*CANVAS_H  canvas bitmap from the cursor stage; bit index = row*CANVAS_W+col, bit 0 top-left, 1 = ink.
REQ-007 SHALL have port i_ready  input  1  downstream classifier accepts the current pixel.
REQ-008 SHALL have port o_valid  output  1  o_pixel/o_row/o_col/o_last are valid.
REQ-009 SHALL have port o_pixel  output  1  current canvas pixel.
REQ-010 SHALL have port o_row, o_col  output  5 each  coordinates of o_pixel.
REQ-011 SHALL have port o_last  output  1  high with the final pixel (index CANVAS_W*CANVAS_H-1).
REQ-012 SHALL have port o_busy  output  1  high in LOAD and STREAM.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse after the final transfer.
REQ-014 SHALL have port o_ink_count  output  10  number of ink pixels in the streamed frame.
REQ-015 SHALL have ports o_bbox_rmin, o_bbox_rmax, o_bbox_cmin, o_bbox_cmax  output  5 each  ink bounding box, plus o_bbox_valid  output  1.

Function
REQ-016 SHALL implement states IDLE, LOAD, STREAM, DONE.
REQ-017 IDLE: i_start=1 SHALL copy i_handwrite into an internal snapshot register and go to LOAD; stats registers cleared the same edge.
REQ-018 LOAD SHALL last exactly one cycle, then go to STREAM with index 0; o_valid rises the first STREAM cycle (i_start edge N -> o_valid at N+2).
REQ-019 Transfer SHALL occur on a cycle with o_valid=1 and i_ready=1; only then the index advances row-major (col 0..CANVAS_W-1, then row+1).
REQ-020 While o_valid=1 and i_ready=0, o_pixel/o_row/o_col/o_last SHALL hold stable.
REQ-021 On each transfer with o_pixel=1, o_ink_count SHALL increment and the bbox mins/maxes SHALL update (min with <, max with >).
REQ-022 Transfer with o_last=1 SHALL go to DONE; DONE SHALL assert o_done for exactly one cycle, o_valid=0, then return to IDLE.
REQ-023 o_ink_count and bbox SHALL be final when o_done=1 and hold until the next accepted i_start.
REQ-024 o_bbox_valid SHALL be 1 iff o_ink_count>0; with zero ink, bbox outputs SHALL read 0.
REQ-025 i_start while not IDLE SHALL be ignored (no restart, no queuing).
REQ-026 Changes on i_handwrite after the snapshot SHALL NOT affect the stream.
REQ-027 i_start in DONE cycle SHALL be ignored; accepted next cycle in IDLE if still high.
REQ-028 o_ink_count SHALL saturate never (max 900 < 1024); width fixed at 10.

Reset
REQ-029 i_rst_n=0 SHALL asynchronously force IDLE, o_valid=0, o_busy=0, o_done=0, o_last=0, o_pixel=0, row/col=0, ink_count=0, bbox=0, bbox_valid=0.
REQ-030 Reset mid-STREAM SHALL abort with no o_done; snapshot contents are don't-care.

Structure
REQ-031 State enum, CANVAS_W/CANVAS_H defaults and coordinate width SHALL live in shared package canvas_pkg.
REQ-032 Bbox/ink tracking SHALL be sub-module canvas_stats (inputs: clear, transfer strobe, pixel, row, col).
REQ-033 Pixel select SHALL use a shift of the snapshot register, not a 900:1 mux.

Verification
REQ-034 Empty canvas, i_ready=1 -> o_valid at start+2, 900 transfers, o_last on row 29 col 29, o_done, ink_count=0, bbox_valid=0.
REQ-035 Single ink bit 465 (row 15, col 15) -> o_pixel=1 only at row 15 col 15; ink_count=1, bbox 15/15/15/15.
REQ-036 i_ready toggling 1/0 each cycle -> outputs stable while low, exactly 900 transfers, stream takes 1800 cycles.
REQ-037 Bits 0 and 899 set, i_handwrite cleared after start -> both pixels streamed, ink_count=2, bbox 0/29/0/29.
REQ-038 i_start pulsed at transfer 100 -> ignored; reset at transfer 500 -> all outputs zero, no o_done, next i_start streams from index 0.
